// File: rtl/stopwatch_cu.sv
// rtl/stopwatch_cu.sv - stopwatch control unit: button sync/edge detect and run/clear/lap FSM
module stopwatch_cu #(
  parameter int CLEAR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_lap,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic       o_lap_hold,
  output logic [1:0] o_state
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  // Bit 0 = run, bit 1 = clear, bit 2 = lap.
  logic [2:0]       s1_q, s2_q, prev_q, press;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign press = s2_q & ~prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STOP: begin
        if (press[0]) begin
          state_d = ST_RUN;
        end else if (press[1]) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (press[0])      state_d = ST_STOP;
        else if (press[2]) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (press[0])      state_d = ST_STOP;
        else if (press[2]) state_d = ST_RUN;
      end
      ST_CLEAR: begin
        // Presses are dropped here; prev_q still tracks so held buttons do not re-fire later.
        if (cnt_q == CNT_LAST) state_d = ST_STOP;
        else                   cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      o_run_stop <= 1'b0;
      o_clear    <= 1'b0;
      o_lap_hold <= 1'b0;
      o_state    <= 2'b00;
    end else begin
      s1_q       <= {i_btn_lap, i_btn_clear, i_btn_run};
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_run_stop <= (state_d == ST_RUN) || (state_d == ST_LAP);
      o_clear    <= (state_d == ST_CLEAR);
      o_lap_hold <= (state_d == ST_LAP);
      o_state    <= state_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_cu.sv
// tb/tb_stopwatch_cu.sv - self-checking bench for stopwatch_cu: vector table, corner sequences, random vs model
module tb_stopwatch_cu;

  localparam int CLEAR_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn = 3'b000;  // {lap, clear, run}
  logic       o_run_stop, o_clear, o_lap_hold;
  logic [1:0] o_state;

  stopwatch_cu #(.CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn_run  (btn[0]),
    .i_btn_clear(btn[1]),
    .i_btn_lap  (btn[2]),
    .o_run_stop (o_run_stop),
    .o_clear    (o_clear),
    .o_lap_hold (o_lap_hold),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: button level history plus stopwatch facts (running, lap frozen, clear cycles left).
  logic [2:0] hist[$];
  bit         m_running, m_lap;
  int         m_clr_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = {3'b000, 3'b000, 3'b000, 3'b000};
    m_running  = 0;
    m_lap      = 0;
    m_clr_left = 0;
  endtask

  // One clock edge: a level seen at edge n acts as a press at edge n+2 if it was low one edge earlier.
  task automatic model_edge(input logic [2:0] lvl);
    logic [2:0] p;
    hist.push_front(lvl);
    p = hist[2] & ~hist[3];
    void'(hist.pop_back());
    if (m_clr_left > 0) begin
      m_clr_left--;
    end else if (!m_running) begin
      if (p[0])      m_running  = 1;
      else if (p[1]) m_clr_left = CLEAR_CYCLES;
    end else begin
      if (p[0]) begin
        m_running = 0;
        m_lap     = 0;
      end else if (p[2]) begin
        m_lap = ~m_lap;
      end
    end
  endtask

  function automatic logic [4:0] model_out();
    logic [1:0] st;
    if (m_clr_left > 0)  st = 2'd2;
    else if (!m_running) st = 2'd0;
    else if (m_lap)      st = 2'd3;
    else                 st = 2'd1;
    return {st, m_running, (m_clr_left > 0), m_lap};
  endfunction

  function automatic logic [4:0] dut_out();
    return {o_state, o_run_stop, o_clear, o_lap_hold};
  endfunction

  task automatic cycle(input logic [2:0] lvl);
    btn = lvl;
    @(posedge clk);
    model_edge(lvl);
    @(negedge clk);
    chk("model", {27'd0, dut_out()}, {27'd0, model_out()});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn   = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_out", {27'd0, dut_out()}, 32'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] btn;
    int         hold;
    logic [1:0] st;
    logic       rs;
    logic       cl;
    logic       lh;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{3'b000, 10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 20, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'b000,  5, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b010,  3, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'b000,  5, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'b100,  4, 2'b11, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{3'b000,  4, 2'b11, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{3'b100,  4, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'b000,  4, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b001,  4, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b000,  4, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b010,  3, 2'b10, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'b011,  2, 2'b10, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{3'b011,  5, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'b000,  4, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{3'b011,  3, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{3'b000,  3, 2'b01, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{3'b101,  3, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{3'b000,  3, 2'b00, 1'b0, 1'b0, 1'b0};

    model_reset();
    do_reset();

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].hold; c++) cycle(vecs[i].btn);
      chk($sformatf("vec%0d", i), {27'd0, dut_out()},
          {27'd0, vecs[i].st, vecs[i].rs, vecs[i].cl, vecs[i].lh});
    end

    // Latency: run level sampled at edge 1, outputs change after edge 3.
    do_reset();
    cycle(3'b001);
    chk("lat_e1", {31'd0, o_run_stop}, 32'd0);
    cycle(3'b001);
    chk("lat_e2", {31'd0, o_run_stop}, 32'd0);
    cycle(3'b001);
    chk("lat_e3", {31'd0, o_run_stop}, 32'd1);
    cycle(3'b000);
    cycle(3'b001);
    cycle(3'b000);
    cycle(3'b000);
    chk("stop_again", {30'd0, o_state}, 32'd0);

    // Async reset partway through CLEAR: outputs drop without a clock edge.
    repeat (2) cycle(3'b010);
    cycle(3'b000);
    chk("clr_cyc1", {31'd0, o_clear}, 32'd1);
    cycle(3'b000);
    chk("clr_cyc2", {30'd0, o_state}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear", {31'd0, o_clear}, 32'd0);
    chk("async_state", {30'd0, o_state}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) cycle(3'b000);
    chk("post_rst_clear", {31'd0, o_clear}, 32'd0);

    // Held across reset release counts as one press.
    @(negedge clk);
    rst_n = 1'b0;
    btn = 3'b001;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) cycle(3'b001);
    chk("held_thru_reset", {30'd0, o_state}, 32'd1);

    // Random button levels, held for random stretches, against the model.
    for (int k = 0; k < 150; k++) begin
      logic [2:0] lvl;
      int         len;
      lvl = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 6);
      for (int c = 0; c < len; c++) cycle(lvl);
      if ($urandom_range(0, 40) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_cu.md
Name: stopwatch_cu

Overview:
- Control unit that sequences the stopwatch tick generator.
- Takes three debounced push-button levels (run/stop, clear, lap) and synchronises and edge-detects them.
- Runs a 4-state Moore FSM that drives the tick generator's run_stop and clear inputs, plus a lap-hold flag for the display path.
- Sits between the button debouncers and the tick_gen/counter datapath.

Parameters:
- CLEAR_CYCLES, default 4: number of clock cycles o_clear is held high per clear request; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_btn_run  input  1  debounced run/stop button level; asynchronous to clk.
- i_btn_clear  input  1  debounced clear button level; asynchronous to clk.
- i_btn_lap  input  1  debounced lap button level; asynchronous to clk.
- o_run_stop  output  1  run enable to the tick generator.
- o_clear  output  1  clear request to the tick generator and counters.
- o_lap_hold  output  1  freezes the displayed time while counting continues.
- o_state  output  2  current FSM state, for debug and LEDs.

Interface decision:
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Input path, per button:
  - 2-FF synchroniser (s1, s2) followed by a prev register.
  - press = s2 & ~prev (one-cycle pulse per rising edge).
  - Falling edges are ignored.
  - A level held high for any number of cycles produces exactly one pulse.
- Reset (rst_n low, async):
  - state = STOP; s1, s2, prev = 0; clear counter = 0.
  - Outputs: o_run_stop=0, o_clear=0, o_lap_hold=0, o_state=2'b00.
  - A button held high across reset release registers as one press.
- States (o_state encoding):
  - STOP=00, RUN=01, CLEAR=10, LAP=11.
- Outputs are decoded from the state register only (Moore, glitch-free):
  - o_run_stop = (RUN | LAP)
  - o_clear = CLEAR
  - o_lap_hold = LAP
- Transitions (evaluated on each posedge clk; press pulses only):
  - STOP: run -> RUN; else clear -> CLEAR; lap ignored.
  - RUN: run -> STOP; else lap -> LAP; clear ignored (must stop first).
  - LAP: run -> STOP (hold released); else lap -> RUN; clear ignored.
  - CLEAR: all presses ignored and discarded, not queued. Stay for exactly CLEAR_CYCLES cycles, then -> STOP.
- Clear counter:
  - Loaded to 0 on entry to CLEAR; increments each cycle in CLEAR.
  - Exit when count == CLEAR_CYCLES-1.
  - Width $clog2(CLEAR_CYCLES+1); no wrap possible.
- Simultaneous presses in the same cycle: priority run > clear > lap. Only one transition per cycle.
- Latency: a button level first sampled high at posedge k produces:
  - press valid after posedge k+1;
  - state/output change after posedge k+2.
  - Total: 3 clock edges, button to output.
- Mid-operation reset (any state, including partway through CLEAR) returns immediately to STOP with all outputs low. The clear pulse is truncated and not resumed.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, no buttons for 10 cycles -> o_state=00, all outputs 0 throughout.
- Run/stop toggle: pulse i_btn_run high for 20 cycles -> o_run_stop rises exactly 3 edges after first sampling and stays high after release. Second press -> o_run_stop=0, o_state=00. Exactly one toggle per press.
- Clear from STOP, CLEAR_CYCLES=4: press clear -> o_clear high for exactly 4 cycles, o_state=10 during, then 00. Pressing run during the clear window has no effect and does not start running afterwards.
- Clear ignored while running: in RUN press clear -> o_state stays 01, o_clear never asserts. Press lap -> o_lap_hold=1, o_run_stop=1, o_state=11. Press lap again -> o_lap_hold=0, o_state=01.
- Simultaneous run+clear edge in STOP -> RUN (o_state=01), o_clear stays 0. Simultaneous run+lap in RUN -> STOP.
- Async reset mid-clear: assert rst_n=0 on 2nd cycle of CLEAR, between clock edges -> o_clear drops immediately (no clock edge needed). After release -> STOP, o_clear stays 0.
